// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache with 4-word lines. Hits answer in the
// request cycle; misses stall while the line is filled one word at a time.
module icache_responder #(
    parameter int LINES  = 32,
    parameter int MEM_TO = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] DataIn,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int IW  = $clog2(LINES);
    localparam int TW  = 13 - IW;
    localparam int TOW = $clog2(MEM_TO + 1);
    localparam logic [TOW-1:0] TO_LIMIT = TOW'(MEM_TO);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

    state_t          state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [15:1]     req_addr_q, req_addr_d;
    logic [1:0]      w_q, w_d;
    logic [TOW-1:0]  to_cnt_q, to_cnt_d;
    logic [15:0]     dout_q, dout_d;
    logic [15:0]     hit_cnt_q, hit_cnt_d;
    logic [15:0]     miss_cnt_q, miss_cnt_d;

    logic [TW-1:0]   tag_mem  [LINES];
    logic [15:0]     data_mem [LINES*4];

    logic            unused_inputs;
    assign unused_inputs = ^{DataIn, createdump};

    logic [IW-1:0]   addr_idx, req_idx;
    logic [TW-1:0]   addr_tag, req_tag;
    logic            illegal, hit, timeout;
    logic [TOW-1:0]  to_next;
    logic [15:0]     hit_word, fin_word;

    assign addr_idx = Addr[3+IW-1:3];
    assign addr_tag = Addr[15:3+IW];
    assign req_idx  = req_addr_q[3+IW-1:3];
    assign req_tag  = req_addr_q[15:3+IW];
    assign illegal  = Wr || (Rd && Addr[0]);
    assign hit      = Rd && !illegal && valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag);
    assign hit_word = data_mem[{addr_idx, Addr[2:1]}];
    assign fin_word = data_mem[{req_idx, req_addr_q[2:1]}];
    assign to_next  = to_cnt_q + TOW'(1);
    // A response arriving in the final allowed cycle still wins over the timeout.
    assign timeout  = (state_q == WAIT) && !mem_rvalid && (to_next == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            req_addr_q <= '0;
            w_q        <= '0;
            to_cnt_q   <= '0;
            dout_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            req_addr_q <= req_addr_d;
            w_q        <= w_d;
            to_cnt_q   <= to_cnt_d;
            dout_q     <= dout_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Line storage has no reset; valid_q alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (!rst && state_q == WAIT && mem_rvalid) begin
            data_mem[{req_idx, w_q}] <= mem_rdata;
            if (w_q == 2'd3) begin
                tag_mem[req_idx] <= req_tag;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        req_addr_d = req_addr_q;
        w_d        = w_q;
        to_cnt_d   = to_cnt_q;
        dout_d     = dout_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (!illegal && Rd) begin
                    if (hit) begin
                        dout_d    = hit_word;
                        hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
                    end else begin
                        req_addr_d = Addr[15:1];
                        w_d        = 2'd0;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                to_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (w_q == 2'd3) begin
                        valid_d[req_idx] = 1'b1;
                        state_d          = FIN;
                    end else begin
                        w_d     = w_q + 2'd1;
                        state_d = REQ;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_next;
                end
            end
            FIN: begin
                dout_d     = fin_word;
                miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Done     = 1'b0;
        Stall    = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = 16'h0000;
        DataOut  = dout_q;
        case (state_q)
            IDLE: begin
                if (illegal) begin
                    err = 1'b1;
                end else if (hit) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    DataOut  = hit_word;
                end else if (Rd) begin
                    Stall = 1'b1;
                end
            end
            REQ: begin
                mem_rd   = 1'b1;
                mem_addr = {req_addr_q[15:3], w_q, 1'b0};
                Stall    = 1'b1;
            end
            WAIT: begin
                if (timeout) begin
                    err = 1'b1;
                end else begin
                    Stall = 1'b1;
                end
            end
            FIN: begin
                Done    = 1'b1;
                DataOut = fin_word;
            end
            default: ;
        endcase
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: fills, hits, conflicts, illegal requests,
// timeout/reset abort and counter saturation against a fixed backing-memory pattern.
module tb_icache_responder;
    localparam int MEM_TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Addr = 16'h0000;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] DataIn = 16'h1234;
    logic        createdump = 1'b0;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, err, mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] hit_cnt, miss_cnt;

    int checks = 0;
    int failures = 0;

    // Backing-memory responder state
    bit          rsp_en = 1'b1;
    int          late_req_n = 0;
    int          late_seen = 0;
    int          mem_rd_count = 0;
    logic [15:0] rd_addr_q[$];
    logic [15:0] rsp_addr;
    logic        rsp_late;

    icache_responder #(.LINES(32), .MEM_TO(MEM_TO)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .Rd(Rd), .Wr(Wr), .DataIn(DataIn),
        .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
        .CacheHit(CacheHit), .err(err), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Backing word at byte address a: {a[7:0]^A5, a[15:8]^3C}
    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C};
    endfunction

    // Responds 3 cycles after each mem_rd pulse; late_req_n requests a stray pulse.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        forever begin
            @(negedge clk);
            rsp_late = 1'b0;
            if (mem_rd) begin
                mem_rd_count++;
                rd_addr_q.push_back(mem_addr);
            end
            if (late_req_n != late_seen) begin
                late_seen = late_req_n;
                rsp_late  = 1'b1;
            end
            if ((mem_rd && rsp_en) || rsp_late) begin
                rsp_addr = mem_addr;
                repeat (3) @(posedge clk);
                #1;
                mem_rdata  = rsp_late ? 16'hDEAD : mem_val(rsp_addr);
                mem_rvalid = 1'b1;
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata  = 16'h0000;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; rsp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs one request expected to miss; returns what the DUT showed at completion.
    task automatic run_fill(input logic [15:0] a, output bit ok, output logic [15:0] data,
                            output logic hit, output bit stall_ok);
        Addr = a; Rd = 1'b1; ok = 1'b0; stall_ok = 1'b1; data = 16'hxxxx; hit = 1'bx;
        @(negedge clk);
        if (!(Stall === 1'b1 && Done === 1'b0)) stall_ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (Done === 1'b1) begin
                ok = 1'b1; data = DataOut; hit = CacheHit;
                if (Stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (Stall !== 1'b1) stall_ok = 1'b0;
        end
        @(posedge clk); #1;
        Rd = 1'b0;
        $display("fill addr=%h done=%0b data=%h hit=%0b", a, ok, data, hit);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({Done, Stall, CacheHit, err, mem_rd} !== 5'b0) begin
            failures++;
            $display("FAIL reset_status got=%b exp=00000", {Done, Stall, CacheHit, err, mem_rd});
        end
        checks++;
        if ({DataOut, mem_addr} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data DataOut=%h mem_addr=%h exp=0000/0000", DataOut, mem_addr);
        end
        checks++;
        if ({hit_cnt, miss_cnt} !== 32'h0) begin
            failures++;
            $display("FAIL reset_counters hit=%h miss=%h exp=0000/0000", hit_cnt, miss_cnt);
        end
        $display("reset done");
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        bit ok, sok; logic [15:0] d; logic h;
        logic [63:0] seq;
        rd_addr_q.delete();
        run_fill(16'h0040, ok, d, h, sok);
        checks++;
        if (!ok || d !== 16'hE53C || h !== 1'b0) begin
            failures++;
            $display("FAIL cold_fill done=%0b data=%h hit=%b exp=1/E53C/0", ok, d, h);
        end
        checks++;
        if (!sok) begin
            failures++;
            $display("FAIL cold_stall stall_ok=%0b exp=1", sok);
        end
        seq = 64'h0;
        if (rd_addr_q.size() == 4) seq = {rd_addr_q[0], rd_addr_q[1], rd_addr_q[2], rd_addr_q[3]};
        checks++;
        if (rd_addr_q.size() != 4 || seq !== 64'h0040_0042_0044_0046) begin
            failures++;
            $display("FAIL cold_mem_addr n=%0d seq=%h exp=4/0040004200440046", rd_addr_q.size(), seq);
        end
        checks++;
        if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
            failures++;
            $display("FAIL cold_counters miss=%h hit=%h exp=0001/0000", miss_cnt, hit_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [3] = '{16'h0042, 16'h0044, 16'h0046};
        logic [15:0] exps  [3] = '{16'hE73C, 16'hE13C, 16'hE33C};
        int c0 = mem_rd_count;
        for (int i = 0; i < 3; i++) begin
            Addr = addrs[i]; Rd = 1'b1;
            @(negedge clk);
            checks++;
            if ({Done, CacheHit, Stall, err} !== 4'b1100 || DataOut !== exps[i]) begin
                failures++;
                $display("FAIL hit_%0d status=%b data=%h exp=1100/%h", i, {Done, CacheHit, Stall, err}, DataOut, exps[i]);
            end
            $display("hit addr=%h data=%h", addrs[i], DataOut);
            @(posedge clk); #1;
        end
        Rd = 1'b0;
        @(negedge clk);
        checks++;
        if (DataOut !== 16'hE33C || Done !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold data=%h done=%b exp=E33C/0", DataOut, Done);
        end
        checks++;
        if (hit_cnt !== 16'd3 || mem_rd_count != c0) begin
            failures++;
            $display("FAIL hit_count hit=%h mem_rds=%0d exp=0003/0", hit_cnt, mem_rd_count - c0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_conflict();
        bit ok, sok; logic [15:0] d; logic h;
        logic [15:0] addrs [3] = '{16'h0040, 16'h0140, 16'h0040};
        logic [15:0] exps  [3] = '{16'hE53C, 16'hE53D, 16'hE53C};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_fill(addrs[i], ok, d, h, sok);
            checks++;
            if (!ok || !sok || d !== exps[i] || h !== 1'b0) begin
                failures++;
                $display("FAIL conflict_%0d done=%0b stall_ok=%0b data=%h hit=%b exp=1/1/%h/0", i, ok, sok, d, h, exps[i]);
            end
        end
        checks++;
        if (miss_cnt !== 16'd3 || hit_cnt !== 16'd0) begin
            failures++;
            $display("FAIL conflict_counters miss=%h hit=%h exp=0003/0000", miss_cnt, hit_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] addrs [3] = '{16'h0040, 16'h0041, 16'h0040};
        logic        wrs   [3] = '{1'b1, 1'b0, 1'b1};
        logic        rds   [3] = '{1'b0, 1'b1, 1'b1};
        int c0 = mem_rd_count;
        for (int i = 0; i < 3; i++) begin
            Addr = addrs[i]; Wr = wrs[i]; Rd = rds[i];
            @(negedge clk);
            checks++;
            if ({err, Done, Stall} !== 3'b100) begin
                failures++;
                $display("FAIL illegal_%0d err/done/stall=%b exp=100", i, {err, Done, Stall});
            end
            $display("illegal addr=%h wr=%b rd=%b err=%b", addrs[i], wrs[i], rds[i], err);
            @(posedge clk); #1;
        end
        Wr = 1'b0; Rd = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || miss_cnt !== 16'd3 || hit_cnt !== 16'd0 || mem_rd_count != c0) begin
            failures++;
            $display("FAIL illegal_after err=%b miss=%h hit=%h mem_rds=%0d exp=0/0003/0000/0", err, miss_cnt, hit_cnt, mem_rd_count - c0);
        end
        @(posedge clk); #1;
        Addr = 16'h0040; Rd = 1'b1;
        @(negedge clk);
        checks++;
        if ({Done, CacheHit} !== 2'b11 || DataOut !== 16'hE53C) begin
            failures++;
            $display("FAIL illegal_line_kept done/hit=%b data=%h exp=11/E53C", {Done, CacheHit}, DataOut);
        end
        @(posedge clk); #1;
        Rd = 1'b0;
    endtask

    task automatic test_timeout_reset();
        int  cnt = 0;
        bit  found = 1'b0, quiet = 1'b1, ok, sok;
        logic [15:0] d; logic h;
        logic done_at_err = 1'b0;
        do_reset();
        rsp_en = 1'b0;
        Addr = 16'h0080; Rd = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            cnt++;
            if (err === 1'b1) begin
                found = 1'b1; done_at_err = Done;
                break;
            end
        end
        checks++;
        if (!found || cnt != MEM_TO + 1 || done_at_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err found=%0b cycles=%0d done=%b exp=1/%0d/0", found, cnt, done_at_err, MEM_TO + 1);
        end
        $display("timeout after %0d cycles", cnt);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || Stall !== 1'b1 || miss_cnt !== 16'd0) begin
            failures++;
            $display("FAIL timeout_remiss err=%b stall=%b miss=%h exp=0/1/0000", err, Stall, miss_cnt);
        end
        // Second fill is now underway; abort it with reset during WAIT.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; Rd = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        late_req_n++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({Done, Stall, err, mem_rd} !== 4'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL reset_abort_quiet quiet=%0b exp=1", quiet);
        end
        rsp_en = 1'b1;
        run_fill(16'h0080, ok, d, h, sok);
        checks++;
        if (!ok || !sok || d !== 16'h253C || h !== 1'b0) begin
            failures++;
            $display("FAIL reset_line_invalid done=%0b miss_seen=%0b data=%h hit=%b exp=1/1/253C/0", ok, sok, d, h);
        end
    endtask

    task automatic test_saturation();
        bit ok, sok; logic [15:0] d; logic h;
        do_reset();
        run_fill(16'h0000, ok, d, h, sok);
        checks++;
        if (!ok || d !== 16'hA53C) begin
            failures++;
            $display("FAIL sat_fill done=%0b data=%h exp=1/A53C", ok, d);
        end
        Addr = 16'h0000; Rd = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        checks++;
        if (hit_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_reach hit=%h exp=FFFF", hit_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hit_cnt !== 16'hFFFF || miss_cnt !== 16'd1 || Done !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold hit=%h miss=%h done=%b exp=FFFF/0001/1", hit_cnt, miss_cnt, Done);
        end
        $display("saturation hit_cnt=%h", hit_cnt);
        Rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_illegal();
        test_timeout_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Read-only, direct-mapped instruction cache. Answers the fetch stage's memory request interface: Addr/Rd/Wr/DataIn/createdump in, DataOut/Done/Stall/CacheHit/err out.
- Hits complete combinationally in the request cycle.
- Misses stall the requester. The block fills a 4-word line from backing memory through a single-outstanding req/valid handshake, then completes with Done.
- Sits between the fetch stage and the unified backing memory.

Parameters:
- LINES, 32, number of cache lines; power of two, 2..256. Index width IW = log2(LINES).
- MEM_TO, 64, cycle limit for one outstanding backing read before the block flags err.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- Addr  in  16  byte address of the requested instruction.
- Rd  in  1  read request.
- Wr  in  1  write request; illegal for this block.
- DataIn  in  16  unused; accepted for interface compatibility.
- createdump  in  1  no functional effect; accepted for interface compatibility.
- DataOut  out  16  instruction word; meaningful only when Done=1.
- Done  out  1  request complete this cycle.
- Stall  out  1  request accepted but not complete; requester holds Addr/Rd.
- CacheHit  out  1  Done cycle was a hit (0 on fill completion).
- err  out  1  illegal request or backing-memory timeout, one cycle.
- mem_rd  out  1  backing read request, one-cycle pulse.
- mem_addr  out  16  backing word address (byte address, bit0=0).
- mem_rdata  in  16  backing read data.
- mem_rvalid  in  1  backing data valid, one cycle.
- hit_cnt  out  16  saturating count of hit completions.
- miss_cnt  out  16  saturating count of fill completions.

Behaviour:
- Address split: Addr[0] byte (must be 0), Addr[2:1] word-in-line, Addr[3+IW-1:3] index, remaining upper bits tag.
- Storage: per line one valid bit (flop vector), tag, and 4x16 data.
- States: IDLE, REQ, WAIT, FIN.
- Reset values: valid vector all 0, state IDLE, Done=0, Stall=0, CacheHit=0, err=0, mem_rd=0, mem_addr=0, DataOut=0, counters=0.
- IDLE with Rd=1, Wr=0, Addr[0]=0, valid and tag match (hit):
  - Same cycle: Done=1, CacheHit=1, Stall=0, DataOut=selected word.
  - hit_cnt increments.
  - State stays IDLE, so back-to-back hits complete every cycle.
- IDLE with legal Rd and a miss:
  - Same cycle: Done=0, Stall=1.
  - Latch Addr into req_addr; word counter w=0; go to REQ.
  - Later changes on Addr/Rd are ignored until FIN.
- REQ:
  - mem_rd=1 and mem_addr={req_addr[15:3], w, 1'b0} for exactly one cycle.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - On mem_rvalid: write mem_rdata into data[index][w].
  - If w<3: w+1, go to REQ.
  - If w==3: write tag and set valid, go to FIN.
  - Timeout counter increments every WAIT cycle. When it reaches MEM_TO: err=1 for one cycle, line stays invalid, go to IDLE with Stall=0 and no Done.
- Stall=1 in every REQ and WAIT cycle.
- FIN:
  - Done=1, CacheHit=0, Stall=0, DataOut=data[index][req_addr[2:1]].
  - miss_cnt increments; go to IDLE.
- Illegal request in IDLE (Wr=1, or Rd=1 with Addr[0]=1):
  - err=1, Done=0, Stall=0 that cycle.
  - No state, array, or counter change.
  - Wr=1 with Rd=1 is also illegal.
- Rd=0 and Wr=0 in IDLE: all status outputs 0. DataOut holds its last value.
- mem_rvalid while in IDLE, REQ or FIN is ignored, with no error.
- Backing data is written on the mem_rvalid edge, so a fill does not depend on mem_rdata at any other time.
- Reset mid-fill aborts the fill:
  - Partially written line remains invalid.
  - A mem_rvalid arriving after reset is ignored.
- Counters saturate at 16'hFFFF.
- Done and Stall are never 1 in the same cycle. Done and err are never 1 in the same cycle.

Test Plan:
- Cold miss: after reset, Rd with Addr=0x0040 and backing rvalid 3 cycles after each mem_rd.
  - Required: mem_addr sequence 0x0040, 0x0042, 0x0044, 0x0046; Stall=1 throughout; FIN gives Done=1, CacheHit=0, DataOut=mem[0x0040]; miss_cnt=1.
- Hit after fill: Addr 0x0042, 0x0044, 0x0046 in consecutive cycles.
  - Required: Done=1, CacheHit=1 each cycle with correct words; hit_cnt=3; no mem_rd.
- Conflict: with LINES=32, read 0x0040, then 0x0140 (same index, different tag), then 0x0040.
  - Required: three fills; the final fill returns the original word.
- Illegal: Wr=1 in IDLE, then Rd=1 with Addr=0x0041.
  - Required: err=1 for one cycle each; Done=0; Stall=0; counters unchanged.
- Timeout and reset: withhold mem_rvalid during the first fill.
  - Required: err pulses after MEM_TO WAIT cycles, then the same address misses again.
  - Also: assert rst during WAIT of a second fill, then send a late mem_rvalid; the block stays IDLE and the line remains invalid.
- Saturation: force 65537 hits.
  - Required: hit_cnt holds at 16'hFFFF.
